// File: rtl/axis_1553_decoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axis_1553_decoder_if                                                  |
// | AXI-Stream word channel carrying decoded 1553 words and status flags. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface axis_1553_decoder_if;
  logic [15:0] tdata;
  logic [7:0]  tuser;
  logic        tvalid;
  logic        tready;

  modport master (output tdata, output tuser, output tvalid, input tready);
  modport slave  (input tdata, input tuser, input tvalid, output tready);
endinterface
`default_nettype wire

// File: rtl/axis_1553_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axis_1553_decoder                                                     |
// | Oversampling Manchester II receiver: sync, 16 data bits, odd parity.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module axis_1553_decoder #(
  parameter int clock_speed = 20000000
) (
  input  wire logic            aclk,
  input  wire logic            arstn,
  input  wire logic [1:0]      diff,
  axis_1553_decoder_if.master  m_axis
);

  localparam int c_H       = clock_speed / 2000000;
  localparam int c_RUN_LO  = 3 * c_H - c_H / 2;
  localparam int c_RUN_HI  = 3 * c_H + c_H / 2;
  localparam int c_RW      = $clog2(c_RUN_HI + 2);
  localparam int c_TW      = $clog2(37 * c_H + 1);

  localparam logic [c_RW-1:0] c_RUN_MIN  = c_RW'(c_RUN_LO);
  localparam logic [c_RW-1:0] c_RUN_MAX  = c_RW'(c_RUN_HI);
  localparam logic [c_TW-1:0] c_SYNC2_T  = c_TW'(3 * c_H / 2);
  localparam logic [c_TW-1:0] c_DATA_T0  = c_TW'(3 * c_H + c_H / 2);
  localparam logic [c_TW-1:0] c_BIT_T    = c_TW'(2 * c_H);
  localparam logic [c_TW-1:0] c_HALF_T   = c_TW'(c_H);
  localparam logic [1:0]      c_LVL_HI   = 2'b10;
  localparam logic [1:0]      c_LVL_LO   = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SYNC2 = 2'd1,
    S_DATA  = 2'd2,
    S_EMIT  = 2'd3
  } state_t;

  state_t            r_state, w_next;
  logic [1:0]        r_sync1, r_sync2;
  logic [1:0]        r_prev;
  logic [c_RW-1:0]   r_run;
  logic [c_TW-1:0]   r_t;
  logic [4:0]        r_k;
  logic              r_half;
  logic [1:0]        r_first;
  logic [15:0]       r_data;
  logic              r_cmd;
  logic              r_man_err;
  logic [15:0]       r_tdata;
  logic [7:0]        r_tuser;
  logic              r_tvalid;

  logic [1:0]        w_lvl;
  logic              w_valid, w_prev_valid, w_sync_edge;
  logic [c_TW-1:0]   w_target;
  logic              w_hit, w_bit, w_bit_err, w_par_err, w_load;

  assign w_lvl        = r_sync2;
  assign w_valid      = (w_lvl == c_LVL_HI) || (w_lvl == c_LVL_LO);
  assign w_prev_valid = (r_prev == c_LVL_HI) || (r_prev == c_LVL_LO);

  // Sample points sit in the middle of each half-bit, counted from the sync mid-edge.
  assign w_target = c_DATA_T0 + c_TW'(r_k) * c_BIT_T + (r_half ? c_HALF_T : c_TW'(0));

  always_comb begin
    w_next      = r_state;
    w_sync_edge = 1'b0;
    w_hit       = 1'b0;
    w_load      = 1'b0;
    w_bit       = (r_first == c_LVL_HI);
    w_bit_err   = !(((r_first == c_LVL_HI) && (w_lvl == c_LVL_LO)) ||
                    ((r_first == c_LVL_LO) && (w_lvl == c_LVL_HI)));
    w_par_err   = ~^{r_data, w_bit};
    case (r_state)
      S_IDLE: begin
        w_sync_edge = w_valid && w_prev_valid && (w_lvl != r_prev) &&
                      (r_run >= c_RUN_MIN) && (r_run <= c_RUN_MAX);
        if (w_sync_edge) w_next = S_SYNC2;
      end
      S_SYNC2: begin
        if (r_t == c_SYNC2_T)
          w_next = (w_lvl == (r_cmd ? c_LVL_LO : c_LVL_HI)) ? S_DATA : S_IDLE;
      end
      S_DATA: begin
        w_hit = (r_t == w_target);
        if (w_hit && r_half && (r_k == 5'd16)) begin
          w_load = 1'b1;
          w_next = S_EMIT;
        end
      end
      S_EMIT:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      r_sync1   <= 2'b00;
      r_sync2   <= 2'b00;
      r_state   <= S_IDLE;
      r_prev    <= 2'b00;
      r_run     <= '0;
      r_t       <= '0;
      r_k       <= 5'd0;
      r_half    <= 1'b0;
      r_first   <= 2'b00;
      r_data    <= 16'h0000;
      r_cmd     <= 1'b0;
      r_man_err <= 1'b0;
    end else begin
      r_sync1 <= diff;
      r_sync2 <= r_sync1;
      r_state <= w_next;
      if (r_state == S_IDLE) begin
        r_prev <= w_lvl;
        if (!w_valid)
          r_run <= '0;
        else if (w_lvl == r_prev) begin
          if (r_run != '1) r_run <= r_run + c_RW'(1);
        end else
          r_run <= c_RW'(1);
        if (w_sync_edge) begin
          r_cmd     <= (r_prev == c_LVL_HI);
          r_t       <= c_TW'(1);
          r_k       <= 5'd0;
          r_half    <= 1'b0;
          r_man_err <= 1'b0;
        end
      end else begin
        // Run tracking restarts from scratch whenever the word ends or aborts.
        r_prev <= w_lvl;
        r_run  <= '0;
        r_t    <= r_t + c_TW'(1);
      end
      if (w_hit) begin
        r_half <= !r_half;
        if (!r_half)
          r_first <= w_lvl;
        else begin
          if (r_k < 5'd16) r_data <= {r_data[14:0], w_bit};
          r_man_err <= r_man_err | w_bit_err;
          r_k       <= r_k + 5'd1;
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      r_tvalid <= 1'b0;
      r_tdata  <= 16'h0000;
      r_tuser  <= 8'h00;
    end else if (w_load) begin
      r_tvalid <= 1'b1;
      r_tdata  <= r_data;
      r_tuser  <= {4'b0000, r_tvalid & ~m_axis.tready, r_man_err | w_bit_err, w_par_err, r_cmd};
    end else if (r_tvalid && m_axis.tready) begin
      r_tvalid <= 1'b0;
    end
  end

  assign m_axis.tdata  = r_tdata;
  assign m_axis.tuser  = r_tuser;
  assign m_axis.tvalid = r_tvalid;

endmodule
`default_nettype wire
